sprite_loader: RTL and testbench

Streams sprite pixel data from a byte source (NIOS PIO or UART bridge) into the per-sprite frame RAMs that `color_mapper` reads. It is the write side of the frame RAM interface: it parses a small packet header, assembles 24-bit RGB pixels, and issues one write per pixel. Pixels are stored row-major at `x + (y << width_log2)`, which is the address form the color mapper uses. Pixel value `KEY` (24'hFF0000) is stored unchanged; transparency remains the reader's job.

---
 rtl/sprite_loader.sv | 187 ++++++++++++++++++
 tb/tb_sprite_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprite_loader: parses sprite packets from a byte stream into frame RAM     |
// | writes. Revision: 1.0                                                      |
// +----------------------------------------------------------------------------+
module sprite_loader #(
  parameter int ADDR_W      = 19,
  parameter int NUM_SPRITES = 8,
  parameter int MAX_W_LOG2  = 9
) (
  input  logic                           Clk_i,
  input  logic                           Reset_i,
  input  logic [7:0]                     byte_in_i,
  input  logic                           byte_valid_i,
  output logic                           byte_ready_o,
  output logic [ADDR_W-1:0]              write_address_o,
  output logic [23:0]                    data_In_o,
  output logic                           we_o,
  output logic [$clog2(NUM_SPRITES)-1:0] sprite_sel_o,
  output logic                           busy_o,
  output logic                           load_done_o,
  output logic                           load_ok_o,
  output logic                           error_o
);

  localparam int         SEL_W         = $clog2(NUM_SPRITES);
  localparam int         WL_W          = $clog2(MAX_W_LOG2 + 1);
  localparam logic [7:0] C_SYNC        = 8'hA5;
  localparam logic [7:0] C_NUM_SPRITES = 8'(NUM_SPRITES);
  localparam logic [7:0] C_MAX_W_LOG2  = 8'(MAX_W_LOG2);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_HDR_ID = 4'd1,
    S_HDR_W  = 4'd2,
    S_HDR_H  = 4'd3,
    S_PIX_R  = 4'd4,
    S_PIX_G  = 4'd5,
    S_PIX_B  = 4'd6,
    S_WRITE  = 4'd7,
    S_CHK    = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  state_t            state_q;
  logic              byte_ready_q;
  logic              we_q;
  logic              load_done_q;
  logic              load_ok_q;
  logic              error_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] pix_count_q;
  logic [23:0]       data_q;
  logic [SEL_W-1:0]  sel_q;
  logic [WL_W-1:0]   wlog2_q;
  logic [7:0]        csum_q;

  logic              accept;
  logic [ADDR_W-1:0] pix_count_d;
  logic [ADDR_W-1:0] cnt_d;

  assign accept      = byte_valid_i && byte_ready_q;
  assign pix_count_d = ADDR_W'(byte_in_i) << wlog2_q;
  assign cnt_d       = cnt_q + ADDR_W'(1);

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      state_q      <= S_IDLE;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      load_done_q  <= 1'b0;
      load_ok_q    <= 1'b0;
      error_q      <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      pix_count_q  <= '0;
      data_q       <= '0;
      sel_q        <= '0;
      wlog2_q      <= '0;
      csum_q       <= '0;
    end else begin
      // Strobes default low; ready only drops for the WRITE and DONE bubbles.
      we_q         <= 1'b0;
      error_q      <= 1'b0;
      load_done_q  <= 1'b0;
      byte_ready_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (accept && byte_in_i == C_SYNC) begin
            csum_q  <= '0;
            state_q <= S_HDR_ID;
          end
        end
        S_HDR_ID: begin
          if (accept) begin
            sel_q <= byte_in_i[SEL_W-1:0];
            if (byte_in_i >= C_NUM_SPRITES) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_HDR_W;
            end
          end
        end
        S_HDR_W: begin
          if (accept) begin
            if (byte_in_i > C_MAX_W_LOG2) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              wlog2_q <= byte_in_i[WL_W-1:0];
              state_q <= S_HDR_H;
            end
          end
        end
        S_HDR_H: begin
          if (accept) begin
            if (byte_in_i == 8'd0) begin
              error_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              pix_count_q <= pix_count_d;
              cnt_q       <= '0;
              state_q     <= S_PIX_R;
            end
          end
        end
        S_PIX_R: begin
          if (accept) begin
            data_q[23:16] <= byte_in_i;
            csum_q        <= csum_q ^ byte_in_i;
            state_q       <= S_PIX_G;
          end
        end
        S_PIX_G: begin
          if (accept) begin
            data_q[15:8] <= byte_in_i;
            csum_q       <= csum_q ^ byte_in_i;
            state_q      <= S_PIX_B;
          end
        end
        S_PIX_B: begin
          if (accept) begin
            data_q[7:0]  <= byte_in_i;
            csum_q       <= csum_q ^ byte_in_i;
            we_q         <= 1'b1;
            addr_q       <= cnt_q;
            byte_ready_q <= 1'b0;
            state_q      <= S_WRITE;
          end
        end
        S_WRITE: begin
          cnt_q   <= cnt_d;
          state_q <= (cnt_d == pix_count_q) ? S_CHK : S_PIX_R;
        end
        S_CHK: begin
          if (accept) begin
            load_ok_q    <= (byte_in_i == csum_q);
            error_q      <= (byte_in_i != csum_q);
            load_done_q  <= 1'b1;
            byte_ready_q <= 1'b0;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_ready_o    = byte_ready_q;
  assign write_address_o = addr_q;
  assign data_In_o       = data_q;
  assign we_o            = we_q;
  assign sprite_sel_o    = sel_q;
  assign busy_o          = (state_q != S_IDLE);
  assign load_done_o     = load_done_q;
  assign load_ok_o       = load_ok_q;
  assign error_o         = error_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sprite_loader: randomized packet stream against a packet-level model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sprite_loader;
  localparam int ADDR_W = 19;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready_o;
  logic [ADDR_W-1:0] write_address_o;
  logic [23:0]       data_In_o;
  logic              we_o;
  logic [2:0]        sprite_sel_o;
  logic              busy_o;
  logic              load_done_o;
  logic              load_ok_o;
  logic              error_o;

  always #5 Clk = ~Clk;

  sprite_loader #(.ADDR_W(ADDR_W), .NUM_SPRITES(8), .MAX_W_LOG2(9)) dut (
    .Clk_i(Clk), .Reset_i(Reset), .byte_in_i(byte_in), .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready_o), .write_address_o(write_address_o), .data_In_o(data_In_o),
    .we_o(we_o), .sprite_sel_o(sprite_sel_o), .busy_o(busy_o), .load_done_o(load_done_o),
    .load_ok_o(load_ok_o), .error_o(error_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Packet-level model: expected outputs for the cycle following each edge.
  bit                started = 1'b0;
  bit                m_acc, m_ready, m_we, m_err, m_done, m_ok, m_busy, in_pkt;
  logic [ADDR_W-1:0] m_addr;
  logic [23:0]       m_data;
  logic [2:0]        m_sel;
  logic [7:0]        m_csum;
  int                pos, wl, npix;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (!in_pkt) begin
      if (b == 8'hA5) begin
        in_pkt = 1'b1;
        pos    = 0;
        m_csum = 8'h00;
      end
      return;
    end
    pos++;
    if (pos == 1) begin
      m_sel = b[2:0];
      if (b >= 8'd8) begin m_err = 1'b1; in_pkt = 1'b0; end
    end else if (pos == 2) begin
      if (b > 8'd9) begin m_err = 1'b1; in_pkt = 1'b0; end
      else wl = int'(b);
    end else if (pos == 3) begin
      if (b == 8'd0) begin m_err = 1'b1; in_pkt = 1'b0; end
      else npix = int'(b) * (1 << wl);
    end else begin
      k = pos - 4;
      if (k < 3 * npix) begin
        case (k % 3)
          0:       m_data[23:16] = b;
          1:       m_data[15:8]  = b;
          default: m_data[7:0]   = b;
        endcase
        m_csum ^= b;
        if (k % 3 == 2) begin
          m_we   = 1'b1;
          m_addr = ADDR_W'(k / 3);
        end
      end else begin
        m_ok   = (b == m_csum);
        m_err  = (b != m_csum);
        m_done = 1'b1;
        in_pkt = 1'b0;
      end
    end
  endtask

  always @(posedge Clk) begin
    cyc++;
    started = 1'b1;
    m_acc   = 1'b0;
    if (!Reset) begin
      m_ready = 1'b0; m_we = 1'b0; m_err = 1'b0; m_done = 1'b0; m_ok = 1'b0;
      m_busy = 1'b0; in_pkt = 1'b0; m_addr = '0; m_data = '0; m_sel = '0;
    end else begin
      m_we = 1'b0; m_err = 1'b0; m_done = 1'b0;
      if (byte_valid && m_ready) begin
        m_acc = 1'b1;
        model_byte(byte_in);
      end
      m_ready = !(m_we || m_done);
      m_busy  = in_pkt || m_done;
    end
  end

  int          wr_cyc[$];
  int          wr_addr[$];
  logic [23:0] wr_data[$];
  logic [2:0]  wr_sel[$];
  int          done_cyc = 0, n_done = 0, n_err = 0;
  logic        done_ok = 1'b0, done_err = 1'b0;

  always @(negedge Clk) begin
    if (started) begin
      cmp("byte_ready", 32'(byte_ready_o), 32'(m_ready));
      cmp("we", 32'(we_o), 32'(m_we));
      cmp("write_address", 32'(write_address_o), 32'(m_addr));
      cmp("data_In", 32'(data_In_o), 32'(m_data));
      cmp("sprite_sel", 32'(sprite_sel_o), 32'(m_sel));
      cmp("busy", 32'(busy_o), 32'(m_busy));
      cmp("load_done", 32'(load_done_o), 32'(m_done));
      cmp("load_ok", 32'(load_ok_o), 32'(m_ok));
      cmp("error", 32'(error_o), 32'(m_err));
      if (we_o === 1'b1) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(write_address_o));
        wr_data.push_back(data_In_o);
        wr_sel.push_back(sprite_sel_o);
      end
      if (load_done_o === 1'b1) begin
        done_cyc = cyc; done_ok = load_ok_o; done_err = error_o; n_done++;
      end
      if (error_o === 1'b1) n_err++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int stall_pct);
    int n = 0;
    bit sent = 1'b0;
    while (!sent) begin
      if (int'($urandom_range(99)) < stall_pct) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_in    = b;
      end
      @(posedge Clk); #1;
      if (m_acc) sent = 1'b1;
      n++;
      if (!sent && n > 1000) begin
        checks++; errors++;
        $display("FAIL byte_timeout at cycle %0d: got no accept expected accept of %0h", cyc, b);
        sent = 1'b1;
      end
    end
  endtask

  task automatic send_pkt(input logic [7:0] p[$], input int stall_pct, output int t0);
    t0 = 0;
    foreach (p[i]) begin
      send_byte(p[i], stall_pct);
      if (i == 0) t0 = cyc;
    end
    byte_valid = 1'b0;
  endtask

  task automatic build(input int id, input int wlog, input int h, input bit bad,
                       output logic [7:0] p[$]);
    logic [7:0] cs, b;
    cs = 8'h00;
    p  = {8'hA5, 8'(id), 8'(wlog), 8'(h)};
    for (int i = 0; i < 3 * h * (1 << wlog); i++) begin
      b = 8'($urandom);
      p.push_back(b);
      cs ^= b;
    end
    p.push_back(bad ? ~cs : cs);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [7:0] p[$];
    int t0, base, ebase, dbase;

    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    cmp("ready_after_reset", 32'(byte_ready_o), 32'd1);
    cmp("busy_after_reset", 32'(busy_o), 32'd0);

    // Minimal 1x1 packet.
    base = wr_cyc.size();
    p = {8'hA5, 8'h02, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'hFF};
    send_pkt(p, 0, t0);
    idle(3);
    cmp("min_nwrites", 32'(wr_cyc.size() - base), 32'd1);
    if (wr_cyc.size() > base) begin
      cmp("min_addr", 32'(wr_addr[base]), 32'd0);
      cmp("min_data", 32'(wr_data[base]), 32'hFF0000);
      cmp("min_sel", 32'(wr_sel[base]), 32'd2);
      cmp("min_we_cycle", 32'(wr_cyc[base] - t0), 32'd6);
    end
    cmp("min_done_cycle", 32'(done_cyc - t0), 32'd8);
    cmp("min_ok", 32'(done_ok), 32'd1);

    // 2x2 sprite; XOR of bytes 01..0C is 0C.
    base = wr_cyc.size();
    p = {8'hA5, 8'h00, 8'h01, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
         8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
    send_pkt(p, 0, t0);
    idle(3);
    cmp("2x2_nwrites", 32'(wr_cyc.size() - base), 32'd4);
    if (wr_cyc.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        cmp("2x2_addr", 32'(wr_addr[base+i]), 32'(i));
        cmp("2x2_data", 32'(wr_data[base+i]),
            32'({8'(3*i+1), 8'(3*i+2), 8'(3*i+3)}));
        if (i > 0) cmp("2x2_spacing", 32'(wr_cyc[base+i] - wr_cyc[base+i-1]), 32'd4);
      end
    end
    cmp("2x2_ok", 32'(done_ok), 32'd1);

    // Header errors, then a good packet.
    base = wr_cyc.size(); ebase = n_err; dbase = n_done;
    p = {8'hA5, 8'h08};               send_pkt(p, 0, t0); idle(2);
    p = {8'hA5, 8'h00, 8'h0A};        send_pkt(p, 0, t0); idle(2);
    p = {8'hA5, 8'h00, 8'h00, 8'h00}; send_pkt(p, 0, t0); idle(2);
    cmp("hdr_err_pulses", 32'(n_err - ebase), 32'd3);
    cmp("hdr_no_writes", 32'(wr_cyc.size() - base), 32'd0);
    cmp("hdr_no_done", 32'(n_done - dbase), 32'd0);
    build(5, 1, 1, 1'b0, p);
    send_pkt(p, 0, t0); idle(3);
    cmp("after_hdr_writes", 32'(wr_cyc.size() - base), 32'd2);
    cmp("after_hdr_ok", 32'(done_ok), 32'd1);

    // Checksum mismatch: 12^34^56 = 70, checksum sent as 00.
    base = wr_cyc.size();
    p = {8'hA5, 8'h03, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h00};
    send_pkt(p, 0, t0); idle(3);
    cmp("bad_cs_write", 32'(wr_cyc.size() - base), 32'd1);
    if (wr_cyc.size() > base) cmp("bad_cs_data", 32'(wr_data[base]), 32'h123456);
    cmp("bad_cs_ok", 32'(done_ok), 32'd0);
    cmp("bad_cs_err_with_done", 32'(done_err), 32'd1);

    // Junk then a randomly stalled packet; writes derived from the packet bytes.
    send_byte(8'h11, 0); send_byte(8'h5A, 0); send_byte(8'h00, 0);
    base = wr_cyc.size();
    build(6, 1, 2, 1'b0, p);
    send_pkt(p, 40, t0); idle(3);
    cmp("stall_nwrites", 32'(wr_cyc.size() - base), 32'd4);
    if (wr_cyc.size() >= base + 4)
      for (int i = 0; i < 4; i++) begin
        cmp("stall_addr", 32'(wr_addr[base+i]), 32'(i));
        cmp("stall_data", 32'(wr_data[base+i]), 32'({p[4+3*i], p[5+3*i], p[6+3*i]}));
      end
    cmp("stall_ok", 32'(done_ok), 32'd1);

    // Randomized packets, occasional junk and bad headers; the model checks every cycle.
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(3) == 0) send_byte(8'($urandom_range(8'hA4)), 20);
      if ($urandom_range(5) == 0) begin
        p = {8'hA5, 8'($urandom_range(8, 255))};
      end else begin
        build(int'($urandom_range(7)), int'($urandom_range(2)), int'($urandom_range(1, 3)),
              $urandom_range(3) == 0, p);
      end
      send_pkt(p, int'($urandom_range(50)), t0);
      idle(int'($urandom_range(3)));
    end
    idle(3);

    // Reset after the G byte of the first pixel: no write may follow.
    base = wr_cyc.size();
    p = {8'hA5, 8'h01, 8'h00, 8'h01, 8'hAB, 8'hCD};
    foreach (p[i]) send_byte(p[i], 0);
    byte_in = 8'hEF; byte_valid = 1'b1; Reset = 1'b0;
    @(posedge Clk); #1;
    cmp("rst_we", 32'(we_o), 32'd0);
    cmp("rst_busy", 32'(busy_o), 32'd0);
    cmp("rst_ready", 32'(byte_ready_o), 32'd0);
    cmp("rst_data", 32'(data_In_o), 32'd0);
    Reset = 1'b1; byte_valid = 1'b0;
    idle(4);
    cmp("rst_no_write", 32'(wr_cyc.size() - base), 32'd0);
    cmp("rst_ready_release", 32'(byte_ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
